// File: rtl/cond_branch_sequencer_pkg.sv
// cond_branch_sequencer_pkg: shared encodings and FSM state for the branch sequencer
package cond_branch_sequencer_pkg;
  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_JMP  = 2'b01;
  localparam logic [1:0] CLS_HALT = 2'b11;
  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_LE     = 3'd3;
  localparam logic [2:0] COND_ALWAYS = 3'd4;
  localparam logic [2:0] COND_NE     = 3'd5;
  localparam logic [2:0] COND_GE     = 3'd6;
  localparam logic [2:0] COND_GT     = 3'd7;
  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, EXEC, WAIT_EX, EVAL, HALT, FAULT} state_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: resolves a 3-bit condition code against a signed 8-bit value
module cond_eval
  import cond_branch_sequencer_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [7:0] value,
  output logic       taken
);
  logic z, n;
  assign z = value == 8'd0;
  assign n = value[7];
  always_comb
    taken = cond == COND_NEVER  ? 1'b0 :
            cond == COND_EQ     ? z :
            cond == COND_LT     ? n :
            cond == COND_LE     ? (n | z) :
            cond == COND_ALWAYS ? 1'b1 :
            cond == COND_NE     ? !z :
            cond == COND_GE     ? !n :
                                  (!n & !z);
endmodule

// File: rtl/cond_branch_sequencer.sv
// cond_branch_sequencer: fetch/exec/branch FSM owning the pc; rst is async active-low
module cond_branch_sequencer
  import cond_branch_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  input  logic [7:0]      acc,
  output logic            exec_valid,
  output logic [7:0]      exec_op,
  input  logic            exec_done,
  output logic [PC_W-1:0] pc,
  output logic            branch_taken,
  output logic            halted,
  output logic            fault
);
  localparam logic [7:0] MAX_W = MAX_WAIT[7:0];
  state_t     state;
  logic [7:0] wait_cnt, target;
  logic [2:0] cond_q;
  logic [1:0] cls;
  logic       taken, timeout;
  assign cls       = imem_data[7:6];
  assign timeout   = wait_cnt == MAX_W;
  assign imem_addr = state == FETCH1 ? pc + PC_W'(1) : pc;
  cond_eval u_cond_eval (.cond(cond_q), .value(acc), .taken(taken));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      exec_valid   <= 1'b0;
      exec_op      <= 8'd0;
      branch_taken <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
      wait_cnt     <= 8'd0;
      target       <= 8'd0;
      cond_q       <= 3'd0;
    end else begin
      exec_valid   <= 1'b0;
      branch_taken <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= FETCH0;
          imem_req <= 1'b1;
          wait_cnt <= 8'd0;
        end
        FETCH0: if (imem_ack) begin
          cond_q   <= imem_data[2:0];
          wait_cnt <= 8'd0;
          if (cls == CLS_ALU) begin
            state      <= EXEC;
            imem_req   <= 1'b0;
            exec_valid <= 1'b1;
            exec_op    <= imem_data;
          end else if (cls == CLS_JMP) begin
            state <= FETCH1;
          end else if (cls == CLS_HALT) begin
            state    <= HALT;
            imem_req <= 1'b0;
            halted   <= 1'b1;
          end else begin
            state    <= FAULT;
            imem_req <= 1'b0;
            fault    <= 1'b1;
          end
        end else if (timeout) begin
          state    <= FAULT;
          imem_req <= 1'b0;
          fault    <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        FETCH1: if (imem_ack) begin
          target   <= imem_data;
          state    <= EVAL;
          imem_req <= 1'b0;
          wait_cnt <= 8'd0;
        end else if (timeout) begin
          state    <= FAULT;
          imem_req <= 1'b0;
          fault    <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        EXEC: state <= WAIT_EX;
        WAIT_EX: if (exec_done) begin
          pc       <= pc + PC_W'(1);
          state    <= FETCH0;
          imem_req <= 1'b1;
          wait_cnt <= 8'd0;
        end
        EVAL: begin
          pc           <= taken ? PC_W'(target) : pc + PC_W'(2);
          branch_taken <= taken;
          state        <= FETCH0;
          imem_req     <= 1'b1;
          wait_cnt     <= 8'd0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cond_branch_sequencer.sv
// tb_cond_branch_sequencer: directed scenario tests for the branch sequencer
module tb_cond_branch_sequencer;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, imem_ack = 1'b0, exec_done = 1'b0;
  logic [7:0] imem_data = 8'd0, acc = 8'd0;
  logic       imem_req, exec_valid, branch_taken, halted, fault;
  logic [7:0] imem_addr, exec_op, pc;
  int passed = 0, total = 0;
  logic [7:0] accs [5];
  logic [4:0] tab [8];
  cond_branch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .acc(acc), .exec_valid(exec_valid),
    .exec_op(exec_op), .exec_done(exec_done), .pc(pc), .branch_taken(branch_taken),
    .halted(halted), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic tick; @(negedge clk); endtask
  task automatic give(input logic [7:0] d);
    imem_ack = 1'b1; imem_data = d; tick(); imem_ack = 1'b0; imem_data = 8'd0;
  endtask
  task automatic do_reset;
    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0; tick(); rst = 1'b1; tick();
  endtask
  task automatic go; start = 1'b1; tick(); start = 1'b0; endtask
  task automatic jump(input logic [7:0] b0, input logic [7:0] tgt, input logic [7:0] a);
    acc = a; give(b0); give(tgt); tick();
  endtask
  task automatic test_reset;
    tick();
    total++; if (pc !== 8'h00) $display("FAIL reset_pc got %h want 00", pc); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else passed++;
    total++; if (exec_op !== 8'h00) $display("FAIL reset_op got %h want 00", exec_op); else passed++;
    total++; if ({exec_valid, branch_taken, halted, fault} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {exec_valid, branch_taken, halted, fault}); else passed++;
    rst = 1'b1; tick(); tick();
    total++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req); else passed++;
  endtask
  task automatic test_alu_halt;
    do_reset(); go();
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL alu_fetch got req=%b addr=%h want 1/00", imem_req, imem_addr); else passed++;
    tick(); tick();
    total++; if (imem_req !== 1'b1) $display("FAIL alu_req_held got %b want 1", imem_req); else passed++;
    give(8'h00);
    total++; if (exec_valid !== 1'b1 || exec_op !== 8'h00 || imem_req !== 1'b0)
      $display("FAIL alu_dispatch got v=%b op=%h req=%b want 1/00/0", exec_valid, exec_op, imem_req); else passed++;
    tick();
    total++; if (exec_valid !== 1'b0) $display("FAIL alu_pulse got %b want 0", exec_valid); else passed++;
    tick(); exec_done = 1'b1; tick(); exec_done = 1'b0;
    total++; if (pc !== 8'h01 || imem_addr !== 8'h01 || imem_req !== 1'b1)
      $display("FAIL alu_next got pc=%h addr=%h req=%b want 01/01/1", pc, imem_addr, imem_req); else passed++;
    give(8'hC0);
    total++; if (halted !== 1'b1 || pc !== 8'h01 || imem_req !== 1'b0)
      $display("FAIL halt got h=%b pc=%h req=%b want 1/01/0", halted, pc, imem_req); else passed++;
    go(); tick();
    total++; if (halted !== 1'b1 || imem_req !== 1'b0) $display("FAIL halt_sticky got h=%b req=%b want 1/0", halted, imem_req); else passed++;
  endtask
  task automatic test_jump;
    do_reset(); go(); acc = 8'h00; give(8'h41);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) $display("FAIL jmp_fetch1 got req=%b addr=%h want 1/01", imem_req, imem_addr); else passed++;
    give(8'h20); tick();
    total++; if (branch_taken !== 1'b1 || pc !== 8'h20) $display("FAIL jmp_taken got bt=%b pc=%h want 1/20", branch_taken, pc); else passed++;
    tick();
    total++; if (branch_taken !== 1'b0) $display("FAIL jmp_pulse got %b want 0", branch_taken); else passed++;
    do_reset(); go(); jump(8'h41, 8'h20, 8'h05);
    total++; if (branch_taken !== 1'b0 || pc !== 8'h02) $display("FAIL jmp_not_taken got bt=%b pc=%h want 0/02", branch_taken, pc); else passed++;
  endtask
  task automatic test_cond_sweep;
    logic [7:0] exp_pc;
    logic       exp;
    accs = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    tab  = '{5'b00000, 5'b00001, 5'b11000, 5'b11001, 5'b11111, 5'b11110, 5'b00111, 5'b00110};
    do_reset(); go(); exp_pc = 8'h00;
    for (int c = 0; c < 8; c++)
      for (int j = 0; j < 5; j++) begin
        jump({5'b01101, c[2:0]}, 8'h20, accs[j]);
        exp = tab[c][j];
        exp_pc = exp ? 8'h20 : exp_pc + 8'h02;
        total++; if (branch_taken !== exp) $display("FAIL cond%0d_acc%h got %b want %b", c, accs[j], branch_taken, exp); else passed++;
        total++; if (pc !== exp_pc) $display("FAIL cond%0d_acc%h_pc got %h want %h", c, accs[j], pc, exp_pc); else passed++;
      end
  endtask
  task automatic test_timeout;
    do_reset(); go(); repeat (15) tick();
    total++; if (fault !== 1'b0 || imem_req !== 1'b1) $display("FAIL to_early got f=%b req=%b want 0/1", fault, imem_req); else passed++;
    tick();
    total++; if (fault !== 1'b1 || imem_req !== 1'b0) $display("FAIL to_fault got f=%b req=%b want 1/0", fault, imem_req); else passed++;
    do_reset(); go(); repeat (15) tick(); give(8'hC0);
    total++; if (fault !== 1'b0 || halted !== 1'b1) $display("FAIL to_ack_wins got f=%b h=%b want 0/1", fault, halted); else passed++;
  endtask
  task automatic test_wrap;
    do_reset(); go(); jump(8'h44, 8'hFF, 8'h80);
    total++; if (pc !== 8'hFF || branch_taken !== 1'b1 || imem_addr !== 8'hFF)
      $display("FAIL wrap_to_ff got pc=%h bt=%b addr=%h want ff/1/ff", pc, branch_taken, imem_addr); else passed++;
    give(8'h40);
    total++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) $display("FAIL wrap_fetch1 got addr=%h req=%b want 00/1", imem_addr, imem_req); else passed++;
    give(8'h10); tick();
    total++; if (pc !== 8'h01 || branch_taken !== 1'b0) $display("FAIL wrap_pc got pc=%h bt=%b want 01/0", pc, branch_taken); else passed++;
    give(8'h80);
    total++; if (fault !== 1'b1 || halted !== 1'b0) $display("FAIL bad_class got f=%b h=%b want 1/0", fault, halted); else passed++;
    go(); tick();
    total++; if (fault !== 1'b1 || imem_req !== 1'b0) $display("FAIL fault_sticky got f=%b req=%b want 1/0", fault, imem_req); else passed++;
  endtask
  task automatic test_reset_mid_exec;
    do_reset(); go(); give(8'h2A);
    total++; if (exec_op !== 8'h2A || exec_valid !== 1'b1) $display("FAIL mid_op1 got op=%h v=%b want 2a/1", exec_op, exec_valid); else passed++;
    tick(); exec_done = 1'b1; tick(); exec_done = 1'b0; give(8'h2B); tick();
    total++; if (pc !== 8'h01 || exec_op !== 8'h2B) $display("FAIL mid_op2 got pc=%h op=%h want 01/2b", pc, exec_op); else passed++;
    exec_done = 1'b1; rst = 1'b0; #1;
    total++; if (pc !== 8'h00 || exec_op !== 8'h00 || imem_req !== 1'b0 || exec_valid !== 1'b0)
      $display("FAIL async_rst got pc=%h op=%h req=%b v=%b want 00/00/0/0", pc, exec_op, imem_req, exec_valid); else passed++;
    tick(); rst = 1'b1; tick(); tick();
    total++; if (pc !== 8'h00 || imem_req !== 1'b0 || exec_valid !== 1'b0)
      $display("FAIL idle_done_ignored got pc=%h req=%b v=%b want 00/0/0", pc, imem_req, exec_valid); else passed++;
    exec_done = 1'b0;
  endtask
  initial begin
    test_reset();
    test_alu_halt();
    test_jump();
    test_cond_sweep();
    test_timeout();
    test_wrap();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
